// File: rtl/hood_pkg.sv
// Shared key indices, arbiter state encoding and the fixed-priority pick
// used by the range-hood key front end.
package hood_pkg;

  // Key positions inside every per-key vector
  localparam int KEY_MENU  = 0;
  localparam int KEY_SPD1  = 1;
  localparam int KEY_SPD2  = 2;
  localparam int KEY_SPD3  = 3;
  localparam int KEY_CLEAN = 4;
  localparam int N_KEYS    = 5;

  // Arbiter states
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_LOCKOUT = 2'd2
  } arb_state_t;

  // Returns a one-hot vector holding only the highest-priority requester:
  // menu > clean > speed3 > speed2 > speed1. All zero when nothing requests.
  function automatic logic [N_KEYS-1:0] pick_winner(input logic [N_KEYS-1:0] req);
    logic [N_KEYS-1:0] win;
    win = '0;
    if (req[KEY_MENU]) begin
      win[KEY_MENU] = 1'b1;
    end else if (req[KEY_CLEAN]) begin
      win[KEY_CLEAN] = 1'b1;
    end else if (req[KEY_SPD3]) begin
      win[KEY_SPD3] = 1'b1;
    end else if (req[KEY_SPD2]) begin
      win[KEY_SPD2] = 1'b1;
    end else if (req[KEY_SPD1]) begin
      win[KEY_SPD1] = 1'b1;
    end
    return win;
  endfunction

endpackage : hood_pkg

// File: rtl/btn_debounce.sv
// One key lane: 2-FF synchroniser, stable-count debouncer and a registered
// one-cycle pulse on each debounced press. Releases produce no pulse.
// Optional stuck-key detection is compiled in with `define STUCK_DETECT_EN:
// a key whose debounced level stays high for STUCK_CYCLES cycles raises
// stuck_o and its press pulses are suppressed until it is released.
module btn_debounce #(
  parameter int          CNT_W           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned STUCK_CYCLES    = 500_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic rise_o,
  output logic stuck_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             db_level_q;
  logic             db_level_d;
  logic             db_prev_q;
  logic [CNT_W-1:0] db_cnt_q;
  logic [CNT_W-1:0] db_cnt_d;
  logic             rise_q;
  logic             stuck_q;

  // Bring the asynchronous key into the clock domain through two flops
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  // Count consecutive cycles where the synced level disagrees with the
  // accepted level; accept the new level once the run is long enough
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (sync_q[1] != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync_q[1];
        db_cnt_d   = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state plus the registered press pulse (masked while stuck)
  always_ff @(posedge clk) begin
    if (reset) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      db_prev_q  <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      db_prev_q  <= db_level_q;
      rise_q     <= db_level_q & ~db_prev_q & ~stuck_q;
    end
  end

`ifdef STUCK_DETECT_EN
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);

  logic [CNT_W-1:0] stuck_cnt_q;

  // Time how long the accepted level has been high; saturate at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else if (!db_level_q) begin
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else if (stuck_cnt_q == STUCK_LAST) begin
      stuck_q <= 1'b1;
    end else begin
      stuck_cnt_q <= stuck_cnt_q + 1'b1;
    end
  end
`else
  // Detection compiled out: the flag is constant low whatever STUCK_CYCLES is
  assign stuck_q = (STUCK_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

  assign rise_o  = rise_q;
  assign stuck_o = stuck_q;

endmodule : btn_debounce

// File: rtl/btn_cmd_arbiter.sv
// Range-hood key front end. Five raw keys are synchronised, debounced and
// edge-detected per lane, then a fixed-priority arbiter turns each accepted
// press into one one-hot command held until the mode FSM takes it, followed
// by a lockout window in which new presses are discarded.
// Optional feature: `define STUCK_DETECT_EN enables per-key stuck detection;
// without it the stuck output is constant zero.
module btn_cmd_arbiter
  import hood_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned LOCKOUT_CYCLES  = 10_000_000,
  parameter int unsigned STUCK_CYCLES    = 500_000_000,
  parameter int          CNT_W           = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_menu,
  input  logic [2:0] raw_speed,
  input  logic       raw_clean,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic       cmd_menu,
  output logic [2:0] cmd_speed,
  output logic       cmd_clean,
  output logic       busy,
  output logic [4:0] stuck
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  logic [N_KEYS-1:0] raw_keys;
  logic [N_KEYS-1:0] key_rise;
  logic [N_KEYS-1:0] key_stuck;
  logic [N_KEYS-1:0] winner;

  arb_state_t        state_q;
  logic [N_KEYS-1:0] pending_q;
  logic [CNT_W-1:0]  lock_cnt_q;
  logic              cmd_valid_q;
  logic              cmd_menu_q;
  logic [2:0]        cmd_speed_q;
  logic              cmd_clean_q;
  logic              busy_q;

  // Gather the raw keys into key-index order
  assign raw_keys[KEY_MENU]  = raw_menu;
  assign raw_keys[KEY_SPD1]  = raw_speed[0];
  assign raw_keys[KEY_SPD2]  = raw_speed[1];
  assign raw_keys[KEY_SPD3]  = raw_speed[2];
  assign raw_keys[KEY_CLEAN] = raw_clean;

  // One identical conditioning lane per key
  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      btn_debounce #(
        .CNT_W          (CNT_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (raw_keys[gi]),
        .rise_o (key_rise[gi]),
        .stuck_o(key_stuck[gi])
      );
    end
  endgenerate

  assign winner = pick_winner(pending_q);

  // Arbiter FSM with registered command outputs. Presses are only collected
  // in IDLE; the cycle that grants discards everything else, including a
  // press pulse arriving in that same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      pending_q   <= '0;
      lock_cnt_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_menu_q  <= 1'b0;
      cmd_speed_q <= 3'b000;
      cmd_clean_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|pending_q) begin
            cmd_valid_q <= 1'b1;
            cmd_menu_q  <= winner[KEY_MENU];
            cmd_speed_q <= {winner[KEY_SPD3], winner[KEY_SPD2], winner[KEY_SPD1]};
            cmd_clean_q <= winner[KEY_CLEAN];
            busy_q      <= 1'b1;
            pending_q   <= '0;
            state_q     <= ARB_GRANT;
          end else begin
            pending_q <= pending_q | key_rise;
          end
        end
        ARB_GRANT: begin
          pending_q <= '0;
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            cmd_menu_q  <= 1'b0;
            cmd_speed_q <= 3'b000;
            cmd_clean_q <= 1'b0;
            lock_cnt_q  <= '0;
            state_q     <= ARB_LOCKOUT;
          end
        end
        ARB_LOCKOUT: begin
          pending_q <= '0;
          if (lock_cnt_q == LOCK_LAST) begin
            lock_cnt_q <= '0;
            busy_q     <= 1'b0;
            state_q    <= ARB_IDLE;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        default: begin
          pending_q   <= '0;
          lock_cnt_q  <= '0;
          cmd_valid_q <= 1'b0;
          cmd_menu_q  <= 1'b0;
          cmd_speed_q <= 3'b000;
          cmd_clean_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ARB_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_menu  = cmd_menu_q;
  assign cmd_speed = cmd_speed_q;
  assign cmd_clean = cmd_clean_q;
  assign busy      = busy_q;
  assign stuck     = key_stuck;

endmodule : btn_cmd_arbiter

// File: tb/tb_btn_cmd_arbiter.sv
// Directed bench for btn_cmd_arbiter with short debounce/lockout/stuck times.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_btn_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_menu;
  logic [2:0] raw_speed;
  logic       raw_clean;
  logic       cmd_ready;
  logic       cmd_valid;
  logic       cmd_menu;
  logic [2:0] cmd_speed;
  logic       cmd_clean;
  logic       busy;
  logic [4:0] stuck;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_cmd_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (8),
    .STUCK_CYCLES   (50),
    .CNT_W          (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_menu (raw_menu),
    .raw_speed(raw_speed),
    .raw_clean(raw_clean),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_menu (cmd_menu),
    .cmd_speed(cmd_speed),
    .cmd_clean(cmd_clean),
    .busy     (busy),
    .stuck    (stuck)
  );

  // Inputs applied for n clocks; expected outputs after the n-th clock.
  // hold=1 additionally requires the command bundle to equal the expected
  // value after every one of the n clocks.
  typedef struct {
    logic       rst;
    logic       menu;
    logic [2:0] speed;
    logic       clean;
    logic       rdy;
    int         n;
    bit         hold;
    logic       ev;
    logic       em;
    logic [2:0] es;
    logic       ec;
    logic       eb;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic menu, logic [2:0] speed, logic clean,
                              logic rdy, int n, bit hold, logic ev, logic em,
                              logic [2:0] es, logic ec, logic eb);
    vec_t v;
    v.rst = rst; v.menu = menu; v.speed = speed; v.clean = clean; v.rdy = rdy;
    v.n = n; v.hold = hold; v.ev = ev; v.em = em; v.es = es; v.ec = ec; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b ({valid,menu,speed,clean,busy,stuck})", name, got, exp);
    end else begin
      $display("ok   %s = %b", name, got);
    end
  endtask

  function automatic logic [11:0] outs();
    return {cmd_valid, cmd_menu, cmd_speed, cmd_clean, busy, stuck};
  endfunction

  initial begin
    logic [11:0] exp_bits;
    logic [5:0]  bad_val;
    bit          hold_ok;

    reset = 1'b1; raw_menu = 1'b0; raw_speed = 3'b000; raw_clean = 1'b0; cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", outs(), 12'b0);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset", outs(), 12'b0);

    // Bouncing speed1: never stable for 4 cycles, so no command ever appears
    hold_ok = 1'b1;
    bad_val = '0;
    for (int i = 0; i < 15; i++) begin
      raw_speed[0] = ~raw_speed[0];
      repeat (2) begin
        @(negedge clk);
        if (cmd_valid !== 1'b0 && hold_ok) begin
          hold_ok = 1'b0;
          bad_val = outs() >> 6;
        end
      end
    end
    raw_speed = 3'b000;
    repeat (10) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0 && hold_ok) begin
        hold_ok = 1'b0;
        bad_val = outs() >> 6;
      end
    end
    check("bounce_no_cmd", {bad_val, 6'b0}, 12'b0);

    //          rst  menu speed   clean rdy n  hold  ev   em   es      ec   eb
    // speed2 press, immediate accept, lockout timing
    vq.push_back(mk(0, 0, 3'b010, 0, 1,  8, 1,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b010, 0, 1,  1, 0,    1,   0,   3'b010, 0,   1));
    vq.push_back(mk(0, 0, 3'b010, 0, 1,  1, 0,    0,   0,   3'b000, 0,   1));
    vq.push_back(mk(0, 0, 3'b010, 0, 1,  7, 1,    0,   0,   3'b000, 0,   1));
    vq.push_back(mk(0, 0, 3'b010, 0, 1,  1, 0,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b000, 0, 1, 12, 1,    0,   0,   3'b000, 0,   0));
    // menu and clean together: menu wins, clean is not queued
    vq.push_back(mk(0, 1, 3'b000, 1, 1,  8, 1,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 1, 3'b000, 1, 1,  1, 0,    1,   1,   3'b000, 0,   1));
    vq.push_back(mk(0, 1, 3'b000, 1, 1,  1, 0,    0,   0,   3'b000, 0,   1));
    vq.push_back(mk(0, 0, 3'b000, 0, 1, 20, 1,    0,   0,   3'b000, 0,   0));
    // clean press with a slow consumer
    vq.push_back(mk(0, 0, 3'b000, 1, 0,  8, 1,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b000, 1, 0,  1, 0,    1,   0,   3'b000, 1,   1));
    vq.push_back(mk(0, 0, 3'b000, 1, 0, 10, 1,    1,   0,   3'b000, 1,   1));
    vq.push_back(mk(0, 0, 3'b000, 1, 1,  1, 0,    0,   0,   3'b000, 0,   1));
    vq.push_back(mk(0, 0, 3'b000, 1, 1,  7, 1,    0,   0,   3'b000, 0,   1));
    vq.push_back(mk(0, 0, 3'b000, 1, 1,  1, 0,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b000, 0, 1, 10, 1,    0,   0,   3'b000, 0,   0));
    // speed3: short press granted, second press debounced inside lockout is dropped
    vq.push_back(mk(0, 0, 3'b100, 0, 1,  4, 1,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b000, 0, 1,  4, 1,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b000, 0, 1,  1, 0,    1,   0,   3'b100, 0,   1));
    vq.push_back(mk(0, 0, 3'b100, 0, 1,  1, 0,    0,   0,   3'b000, 0,   1));
    vq.push_back(mk(0, 0, 3'b100, 0, 1,  7, 1,    0,   0,   3'b000, 0,   1));
    vq.push_back(mk(0, 0, 3'b100, 0, 1,  1, 0,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b100, 0, 1, 10, 1,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b000, 0, 1, 10, 1,    0,   0,   3'b000, 0,   0));
    // same press once idle again is granted
    vq.push_back(mk(0, 0, 3'b100, 0, 1,  8, 1,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b100, 0, 1,  1, 0,    1,   0,   3'b100, 0,   1));
    vq.push_back(mk(0, 0, 3'b000, 0, 1,  1, 0,    0,   0,   3'b000, 0,   1));
    vq.push_back(mk(0, 0, 3'b000, 0, 1, 12, 1,    0,   0,   3'b000, 0,   0));
    // reset while a menu command is waiting in GRANT
    vq.push_back(mk(0, 1, 3'b000, 0, 0,  8, 1,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 1, 3'b000, 0, 0,  1, 0,    1,   1,   3'b000, 0,   1));
    vq.push_back(mk(1, 0, 3'b000, 0, 0,  1, 0,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b000, 0, 0, 10, 1,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b001, 0, 1,  8, 1,    0,   0,   3'b000, 0,   0));
    vq.push_back(mk(0, 0, 3'b001, 0, 1,  1, 0,    1,   0,   3'b001, 0,   1));
    vq.push_back(mk(0, 0, 3'b000, 0, 1,  1, 0,    0,   0,   3'b000, 0,   1));
    vq.push_back(mk(0, 0, 3'b000, 0, 1, 12, 1,    0,   0,   3'b000, 0,   0));

    foreach (vq[i]) begin
      reset     = vq[i].rst;
      raw_menu  = vq[i].menu;
      raw_speed = vq[i].speed;
      raw_clean = vq[i].clean;
      cmd_ready = vq[i].rdy;
      exp_bits  = {vq[i].ev, vq[i].em, vq[i].es, vq[i].ec, vq[i].eb, 5'b00000};
      hold_ok   = 1'b1;
      bad_val   = exp_bits[11:6];
      for (int s = 0; s < vq[i].n; s++) begin
        @(negedge clk);
        if (vq[i].hold && hold_ok && (outs() >> 6) !== {26'b0, exp_bits[11:6]}) begin
          hold_ok = 1'b0;
          bad_val = outs() >> 6;
        end
      end
      if (vq[i].hold) begin
        check($sformatf("row%0d_hold", i), {bad_val, 6'b0}, {exp_bits[11:6], 6'b0});
      end
      check($sformatf("row%0d", i), outs(), exp_bits);
    end
    reset = 1'b0;

`ifdef STUCK_DETECT_EN
    // Menu held 60 cycles: one command, then stuck, then release clears it
    raw_menu  = 1'b1;
    cmd_ready = 1'b1;
    repeat (10) @(negedge clk);
    hold_ok = 1'b1;
    bad_val = '0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0 && hold_ok) begin
        hold_ok = 1'b0;
        bad_val = outs() >> 6;
      end
    end
    check("stuck_no_cmd", {bad_val, 6'b0}, 12'b0);
    check("stuck_set", outs(), 12'b000000_0_00001);
    raw_menu = 1'b0;
    repeat (12) @(negedge clk);
    check("stuck_clear", outs(), 12'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_btn_cmd_arbiter
